// File: rtl/dsp_term_pkg.sv
// rtl/dsp_term_pkg.sv - shared states, byte codes and cell-address helper for dsp_term
package dsp_term_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUT     = 2'd1,
        ST_CLRLINE = 2'd2,
        ST_CLRSCR  = 2'd3
    } state_t;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_BLANK = 8'h20;

    function automatic logic [11:0] make_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/dsp_term_cursor.sv
// rtl/dsp_term_cursor.sv - cursor row/column registers driven by one-hot FSM commands
module dsp_term_cursor
    import dsp_term_pkg::*;
#(
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_inc,
    input  logic       cmd_cr,
    input  logic       cmd_nl,
    input  logic       cmd_bs,
    input  logic       cmd_home,
    output logic [4:0] row,
    output logic [6:0] col,
    output logic [4:0] row_adv
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // Exposed so the FSM can address the freshly entered line in the same edge.
    assign row_adv = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= 5'd0;
            col <= 7'd0;
        end else if (cmd_home) begin
            row <= 5'd0;
            col <= 7'd0;
        end else if (cmd_nl) begin
            row <= row_adv;
            col <= 7'd0;
        end else if (cmd_cr) begin
            col <= 7'd0;
        end else if (cmd_bs) begin
            if (col != 7'd0) col <= col - 7'd1;
        end else if (cmd_inc) begin
            col <= col + 7'd1;
        end
    end

endmodule

// File: rtl/dsp_term.sv
// rtl/dsp_term.sv - byte-stream terminal engine driving dsp writes; DSP_TERM_CLEAR_EN adds form-feed/power-up screen clear
module dsp_term
    import dsp_term_pkg::*;
#(
    parameter int         COLS = 80,
    parameter int         ROWS = 30,
    parameter logic [7:0] ATTR = 8'h07
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    output logic        dsp_en,
    output logic        dsp_wr,
    output logic [11:0] dsp_addr,
    output logic [15:0] dsp_data,
    input  logic        dsp_wt,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col
);

    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [15:0] BLANK_CELL = {ATTR, CHR_BLANK};
`ifdef DSP_TERM_CLEAR_EN
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
`endif

    state_t      state, state_d;
    logic [6:0]  clr_col, clr_col_d;
    logic        ch_ready_d, en_d;
    logic [11:0] addr_d;
    logic [15:0] data_d;
    logic        cmd_inc, cmd_cr, cmd_nl, cmd_bs, cmd_home;
    logic [4:0]  row_adv;
    logic        accept, done, printable;
`ifdef DSP_TERM_CLEAR_EN
    logic [4:0]  clr_row, clr_row_d;
    logic        init_done;
`endif

    assign accept    = ch_valid & ch_ready;
    assign done      = dsp_en & ~dsp_wt;
    assign printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
    assign dsp_wr    = dsp_en;

    dsp_term_cursor #(.ROWS(ROWS)) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .cmd_inc  (cmd_inc),
        .cmd_cr   (cmd_cr),
        .cmd_nl   (cmd_nl),
        .cmd_bs   (cmd_bs),
        .cmd_home (cmd_home),
        .row      (cur_row),
        .col      (cur_col),
        .row_adv  (row_adv)
    );

    // Next-state and next-output values; the bus outputs are registered below.
    always_comb begin
        state_d   = state;
        clr_col_d = clr_col;
        en_d      = 1'b0;
        addr_d    = 12'd0;
        data_d    = 16'd0;
        cmd_inc   = 1'b0;
        cmd_cr    = 1'b0;
        cmd_nl    = 1'b0;
        cmd_bs    = 1'b0;
        cmd_home  = 1'b0;
`ifdef DSP_TERM_CLEAR_EN
        clr_row_d = clr_row;
`endif
        case (state)
            ST_IDLE: begin
`ifdef DSP_TERM_CLEAR_EN
                if (!init_done || (accept && ch_data == CHR_FF)) begin
                    state_d   = ST_CLRSCR;
                    clr_col_d = 7'd0;
                    clr_row_d = 5'd0;
                    en_d      = 1'b1;
                    addr_d    = make_addr(5'd0, 7'd0);
                    data_d    = BLANK_CELL;
                end else
`endif
                if (accept) begin
                    if (printable) begin
                        state_d = ST_PUT;
                        en_d    = 1'b1;
                        addr_d  = make_addr(cur_row, cur_col);
                        data_d  = {ATTR, ch_data};
                    end else if (ch_data == CHR_CR) begin
                        cmd_cr = 1'b1;
                    end else if (ch_data == CHR_LF) begin
                        cmd_nl    = 1'b1;
                        state_d   = ST_CLRLINE;
                        clr_col_d = 7'd0;
                        en_d      = 1'b1;
                        addr_d    = make_addr(row_adv, 7'd0);
                        data_d    = BLANK_CELL;
                    end else if (ch_data == CHR_BS) begin
                        cmd_bs = 1'b1;
                    end
                end
            end
            ST_PUT: begin
                if (done) begin
                    if (cur_col < LAST_COL) begin
                        cmd_inc = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cmd_nl    = 1'b1;
                        state_d   = ST_CLRLINE;
                        clr_col_d = 7'd0;
                        en_d      = 1'b1;
                        addr_d    = make_addr(row_adv, 7'd0);
                        data_d    = BLANK_CELL;
                    end
                end else begin
                    en_d   = 1'b1;
                    addr_d = dsp_addr;
                    data_d = dsp_data;
                end
            end
            ST_CLRLINE: begin
                if (done) begin
                    if (clr_col == LAST_COL) begin
                        state_d = ST_IDLE;
                    end else begin
                        clr_col_d = clr_col + 7'd1;
                        en_d      = 1'b1;
                        addr_d    = make_addr(cur_row, clr_col_d);
                        data_d    = BLANK_CELL;
                    end
                end else begin
                    en_d   = 1'b1;
                    addr_d = dsp_addr;
                    data_d = dsp_data;
                end
            end
`ifdef DSP_TERM_CLEAR_EN
            ST_CLRSCR: begin
                if (done) begin
                    if (clr_col == LAST_COL && clr_row == LAST_ROW) begin
                        cmd_home = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        if (clr_col == LAST_COL) begin
                            clr_col_d = 7'd0;
                            clr_row_d = clr_row + 5'd1;
                        end else begin
                            clr_col_d = clr_col + 7'd1;
                        end
                        en_d   = 1'b1;
                        addr_d = make_addr(clr_row_d, clr_col_d);
                        data_d = BLANK_CELL;
                    end
                end else begin
                    en_d   = 1'b1;
                    addr_d = dsp_addr;
                    data_d = dsp_data;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        ch_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            clr_col  <= 7'd0;
            ch_ready <= 1'b0;
            dsp_en   <= 1'b0;
            dsp_addr <= 12'd0;
            dsp_data <= 16'd0;
`ifdef DSP_TERM_CLEAR_EN
            clr_row   <= 5'd0;
            init_done <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            clr_col  <= clr_col_d;
            ch_ready <= ch_ready_d;
            dsp_en   <= en_d;
            dsp_addr <= addr_d;
            dsp_data <= data_d;
`ifdef DSP_TERM_CLEAR_EN
            clr_row   <= clr_row_d;
            init_done <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_dsp_term.sv
// tb/tb_dsp_term.sv - scoreboard bench for dsp_term (covers DSP_TERM_CLEAR_EN when defined)
module tb_dsp_term;

    logic        clk = 1'b0;
    logic        reset;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        dsp_en;
    logic        dsp_wr;
    logic [11:0] dsp_addr;
    logic [15:0] dsp_data;
    logic        dsp_wt;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [27:0] exp_q[$];
    int          m_row, m_col;

    always #5 clk = ~clk;

    dsp_term dut (
        .clk      (clk),
        .reset    (reset),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_ready (ch_ready),
        .dsp_en   (dsp_en),
        .dsp_wr   (dsp_wr),
        .dsp_addr (dsp_addr),
        .dsp_data (dsp_data),
        .dsp_wt   (dsp_wt),
        .cur_row  (cur_row),
        .cur_col  (cur_col)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every completed access pops one expected {addr,data}; idle bus must be zero.
    always @(negedge clk) begin
        logic [27:0] e;
        if (reset) begin
            if (dsp_en && !dsp_wt) begin
                check("wr_eq_en", {31'd0, dsp_wr}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h/%h expected none", dsp_addr, dsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {4'h0, dsp_addr, dsp_data}, {4'h0, e});
                end
            end else if (!dsp_en) begin
                check("idle_bus_zero", {4'h0, dsp_addr, dsp_data}, 32'd0);
            end
        end
    end

    task automatic push_clear(input int row);
        for (int c = 0; c < 80; c++) exp_q.push_back({5'(row), 7'(c), 16'h0720});
    endtask

    task automatic push_screen();
        for (int r = 0; r < 30; r++) push_clear(r);
    endtask

    task automatic adv_row();
        m_row = (m_row == 29) ? 0 : m_row + 1;
        m_col = 0;
        push_clear(m_row);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({5'(m_row), 7'(m_col), 8'h07, b});
            if (m_col < 79) m_col++;
            else adv_row();
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            adv_row();
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end
`ifdef DSP_TERM_CLEAR_EN
        else if (b == 8'h0C) begin
            push_screen();
            m_row = 0;
            m_col = 0;
        end
`endif
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!ch_ready && t < 6000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!ch_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got ch_ready=0 expected 1 within 6000 cycles", name);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready("ready_timeout");
        ch_data  = b;
        ch_valid = 1'b1;
        @(posedge clk);
        #1;
        ch_valid = 1'b0;
    endtask

    task automatic tx(input logic [7:0] b);
        model_byte(b);
        send_byte(b);
    endtask

    task automatic drain(input string name);
        wait_ready(name);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic check_cur(input string name, input int r, input int c);
        check(name, {20'd0, cur_row, cur_col}, {20'd0, 5'(r), 7'(c)});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before 3 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        dsp_wt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ch_ready", {31'd0, ch_ready}, 32'd0);
        check("rst_dsp_en", {31'd0, dsp_en}, 32'd0);
        check("rst_bus", {4'h0, dsp_addr, dsp_data}, 32'd0);
        check_cur("rst_cursor", 0, 0);

        reset = 1'b1;
        m_row = 0;
        m_col = 0;
`ifdef DSP_TERM_CLEAR_EN
        push_screen();
        drain("powerup_clear");
`endif

        // 'A' with no wait states
        exp_q.push_back(28'h000_0741);
        send_byte(8'h41);
        m_col = 1;
        check("a_ready_low", {31'd0, ch_ready}, 32'd0);
        check("a_en_next_cycle", {31'd0, dsp_en}, 32'd1);
        @(posedge clk);
        #1;
        check("a_ready_back", {31'd0, ch_ready}, 32'd1);
        check_cur("a_cursor", 0, 1);

        // 'B' stretched by three wait cycles
        dsp_wt = 1'b1;
        exp_q.push_back({12'h001, 16'h0742});
        send_byte(8'h42);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                @(posedge clk);
                #1;
                dsp_wt = 1'b0;
            end
            @(negedge clk);
            check("b_hold_en", {31'd0, dsp_en}, 32'd1);
            check("b_hold_bus", {4'h0, dsp_addr, dsp_data}, {4'h0, 12'h001, 16'h0742});
            check("b_hold_col", {25'd0, cur_col}, 32'd1);
        end
        @(posedge clk);
        #1;
        m_col = 2;
        check_cur("b_cursor", 0, 2);

        tx(8'h0D);
        check_cur("cr_row0", 0, 0);
        tx(8'h08);
        check_cur("bs_col0_row0", 0, 0);
        tx(8'h7F);
        tx(8'h80);
`ifndef DSP_TERM_CLEAR_EN
        tx(8'h0C);
`endif
        drain("dropped_no_write");
        check_cur("dropped_cursor", 0, 0);

        for (int i = 0; i < 5; i++) tx(8'h0A);
        for (int i = 0; i < 10; i++) tx(8'h61 + 8'(i));
        drain("reach_5_10");
        check_cur("cursor_5_10", 5, 10);
        tx(8'h08);
        check_cur("bs_nonzero", 5, 9);
        tx(8'h78);
        drain("overwrite_5_9");
        check_cur("cursor_back_5_10", 5, 10);

        tx(8'h0D);
        check_cur("cr_5", 5, 0);
        tx(8'h08);
        check_cur("bs_col0_5", 5, 0);
        tx(8'h0A);
        check("lf_first_addr", {20'd0, dsp_addr}, 32'h300);
        drain("lf_row6_clear");
        check_cur("lf_cursor", 6, 0);

        for (int i = 0; i < 23; i++) tx(8'h0A);
        for (int i = 0; i < 79; i++) tx(8'h30 + 8'(i % 10));
        drain("reach_29_79");
        check_cur("cursor_29_79", 29, 79);

        // last cell on the screen: wraps to row 0 and clears it
        exp_q.push_back({12'hECF, 16'h075A});
        push_clear(0);
        m_row = 0;
        m_col = 0;
        send_byte(8'h5A);
        check("z_addr", {20'd0, dsp_addr}, 32'hECF);
        drain("wrap_clear_row0");
        check_cur("wrap_cursor", 0, 0);

        // reset while clearing row 1 at column 40
        for (int c = 0; c < 40; c++) exp_q.push_back({5'd1, 7'(c), 16'h0720});
        send_byte(8'h0A);
        begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(dsp_en && dsp_addr == {5'd1, 7'd39}) && t < 200);
            check("mid_clear_reached", {31'd0, dsp_en}, 32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_en", {31'd0, dsp_en}, 32'd0);
        check("abort_bus", {4'h0, dsp_addr, dsp_data}, 32'd0);
        check_cur("abort_cursor", 0, 0);
        check("abort_queue", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_row = 0;
        m_col = 0;
`ifdef DSP_TERM_CLEAR_EN
        push_screen();
`endif
        drain("after_abort");
        repeat (50) @(posedge clk);
        #1;
        check("no_resume", exp_q.size(), 32'd0);
        check_cur("after_abort_cursor", 0, 0);

`ifdef DSP_TERM_CLEAR_EN
        tx(8'h51);
        tx(8'h0A);
        drain("pre_ff");
        check_cur("pre_ff_cursor", 1, 0);
        tx(8'h0C);
        check("ff_ready_low", {31'd0, ch_ready}, 32'd0);
        check("ff_first_addr", {20'd0, dsp_addr}, 32'h000);
        drain("ff_clear");
        check_cur("ff_cursor", 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
